// File: rtl/rgen_apb_bridge.sv
// APB3 target that turns each transfer into one held command toward a generated
// register block, then completes the access from the block's response strobe or a timeout.
module rgen_apb_bridge #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_psel,
    input  logic                     i_penable,
    input  logic                     i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0]    i_pwdata,
    output logic                     o_pready,
    output logic [DATA_WIDTH-1:0]    o_prdata,
    output logic                     o_pslverr,
    output logic                     o_command_valid,
    output logic [ADDRESS_WIDTH-1:0] o_command_address,
    output logic                     o_command_write,
    output logic [DATA_WIDTH-1:0]    o_command_write_data,
    input  logic                     i_response_ready,
    input  logic [DATA_WIDTH-1:0]    i_read_data,
    input  logic [1:0]               i_status
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pready_q, pready_d;
    logic [DATA_WIDTH-1:0]    prdata_q, prdata_d;
    logic                     pslverr_q, pslverr_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic [ADDRESS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic                     cmd_write_q, cmd_write_d;
    logic [DATA_WIDTH-1:0]    cmd_wdata_q, cmd_wdata_d;
    logic                     timeout_hit;

    // The exokay flag carries no meaning on APB3.
    logic unused_status_exokay;
    assign unused_status_exokay = i_status[1];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pready_d    = 1'b0;
        prdata_d    = '0;
        pslverr_d   = 1'b0;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_write_d = cmd_write_q;
        cmd_wdata_d = cmd_wdata_q;

        case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    cmd_addr_d  = i_paddr;
                    cmd_write_d = i_pwrite;
                    cmd_wdata_d = i_pwdata;
                    cmd_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = CMD;
                end
            end
            CMD: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response sampled together with the timeout still completes normally.
                if (i_response_ready) begin
                    state_d     = DONE;
                    pready_d    = 1'b1;
                    pslverr_d   = i_status[0];
                    prdata_d    = cmd_write_q ? '0 : i_read_data;
                    cmd_valid_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    pready_d    = 1'b1;
                    pslverr_d   = 1'b1;
                    cmd_valid_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_write_q <= 1'b0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_write_q <= cmd_write_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    assign o_pready             = pready_q;
    assign o_prdata             = prdata_q;
    assign o_pslverr            = pslverr_q;
    assign o_command_valid      = cmd_valid_q;
    assign o_command_address    = cmd_addr_q;
    assign o_command_write      = cmd_write_q;
    assign o_command_write_data = cmd_wdata_q;

endmodule
